// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester arbiter and sequencer for the shared combinational VeriRISC
// ALU. Requests from two masters arrive over valid/ready handshakes and are
// granted one at a time, round-robin. The granted operands are registered
// onto the ALU inputs and held for SETTLE cycles. The ALU result (y/z) is then
// captured and returned on a single response channel tagged with the
// requester id.
//
// Parameters:
//   WIDTH  - operand/result width (must match the ALU width)
//   SETTLE - cycles the ALU inputs are held before capture (legal 1..15)
//
// Ports:
//   clk_in, rst_n_in              clock (rising edge), async active-low reset
//   req{0,1}_valid_in/_ready_out  request handshake per requester
//   req{0,1}_a_in/_b_in/_op_in    request operands and opcode
//   rsp_valid_out/rsp_ready_in    response handshake
//   rsp_id_out                    requester served (0/1)
//   rsp_y_out/rsp_z_out           captured ALU result and zero flag
//   rsp_err_out                   unsupported opcode flag
//   alu_a_out/alu_b_out/alu_op_out  registered ALU operands/opcode
//   alu_y_in/alu_z_in             ALU result and zero flag
//   busy_out                      high whenever the FSM is not IDLE
//
// Build option:
//   ALU_ARB_OPCHECK_EN - when defined, opcodes 011/101/110/111 are rejected at
//   accept: the ALU inputs are left untouched, EXEC is skipped and the
//   response is y=0, z=1, err=1. When undefined, every opcode goes to the
//   ALU and rsp_err_out is tied 0.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,

  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic [WIDTH-1:0] req0_a_in,
  input  logic [WIDTH-1:0] req0_b_in,
  input  logic [2:0]       req0_op_in,

  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic [WIDTH-1:0] req1_a_in,
  input  logic [WIDTH-1:0] req1_b_in,
  input  logic [2:0]       req1_op_in,

  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic             rsp_id_out,
  output logic [WIDTH-1:0] rsp_y_out,
  output logic             rsp_z_out,
  output logic             rsp_err_out,

  output logic [WIDTH-1:0] alu_a_out,
  output logic [WIDTH-1:0] alu_b_out,
  output logic [2:0]       alu_op_out,
  input  logic [WIDTH-1:0] alu_y_in,
  input  logic             alu_z_in,

  output logic             busy_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The counter is loaded with SETTLE-1 so that the capture happens on the
  // SETTLE-th edge after accept. SETTLE must lie in 1..15 to fit 4 bits.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             prio_reg;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic [2:0]       alu_op_reg;
  logic             id_reg;
  logic [WIDTH-1:0] rsp_y_reg;
  logic             rsp_z_reg;

  // Requester views gathered into arrays so the per-requester logic can be
  // generated once.
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_a  [2];
  logic [WIDTH-1:0] req_b  [2];
  logic [2:0]       req_op [2];
  logic [1:0]       ready;

  assign req_valid = {req1_valid_in, req0_valid_in};
  assign req_a[0]  = req0_a_in;
  assign req_a[1]  = req1_a_in;
  assign req_b[0]  = req0_b_in;
  assign req_b[1]  = req1_b_in;
  assign req_op[0] = req0_op_in;
  assign req_op[1] = req1_op_in;

  // Grant: a lone valid requester wins outright; with both valid (or none)
  // the round-robin pointer decides.
  logic grant;
  always_comb begin
    grant = prio_reg;
    if (req_valid == 2'b01) begin
      grant = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign ready[gi] = (state_reg == ST_IDLE) && req_valid[gi] && (grant == 1'(gi));
    end
  endgenerate

  assign req0_ready_out = ready[0];
  assign req1_ready_out = ready[1];

  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;

  assign accept = |ready;
  assign sel_a  = req_a[grant];
  assign sel_b  = req_b[grant];
  assign sel_op = req_op[grant];

  // Opcodes the ALU does not implement.
  logic op_bad;
`ifdef ALU_ARB_OPCHECK_EN
  assign op_bad = (sel_op == 3'b011) || (sel_op == 3'b101) ||
                  (sel_op == 3'b110) || (sel_op == 3'b111);
`else
  assign op_bad = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = op_bad ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // rsp_valid_out is exactly (state == RESP), so rsp_ready_in alone
        // completes the handshake here.
        if (rsp_ready_in) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg  <= ST_IDLE;
      prio_reg   <= 1'b0;
      cnt_reg    <= 4'd0;
      alu_a_reg  <= '0;
      alu_b_reg  <= '0;
      alu_op_reg <= 3'b000;
      id_reg     <= 1'b0;
      rsp_y_reg  <= '0;
      rsp_z_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            id_reg <= grant;
            if (op_bad) begin
              // Rejected op: the ALU inputs keep their previous values and
              // the response is synthesised directly.
              rsp_y_reg <= '0;
              rsp_z_reg <= 1'b1;
            end else begin
              alu_a_reg  <= sel_a;
              alu_b_reg  <= sel_b;
              alu_op_reg <= sel_op;
              cnt_reg    <= SETTLE_LOAD;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_reg == 4'd0) begin
            rsp_y_reg <= alu_y_in;
            rsp_z_reg <= alu_z_in;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          // Hand priority to the requester that was not just served, so a
          // continuously waiting loser goes next.
          if (rsp_ready_in) begin
            prio_reg <= ~id_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_reg;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rsp_err_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE) && accept) begin
      rsp_err_reg <= op_bad;
    end
  end
  assign rsp_err_out = rsp_err_reg;
`else
  assign rsp_err_out = 1'b0;
`endif

  assign rsp_valid_out = (state_reg == ST_RESP);
  assign rsp_id_out    = id_reg;
  assign rsp_y_out     = rsp_y_reg;
  assign rsp_z_out     = rsp_z_reg;
  assign alu_a_out     = alu_a_reg;
  assign alu_b_out     = alu_b_reg;
  assign alu_op_out    = alu_op_reg;
  assign busy_out      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. u_dut runs with SETTLE=1 and covers the
// handshake, arbitration, backpressure, zero results and the opcode check.
// u_dut4 runs with SETTLE=4 and covers mid-operation reset and latency.
// Each DUT is paired with a small behavioural VeriRISC ALU.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W = 32;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- u_dut (SETTLE=1) ----------------
  logic         rst_n;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]   r0_op, r1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_err;
  logic [W-1:0] rsp_y;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_op;
  logic         alu_z, busy;

  alu_arbiter #(.WIDTH(W), .SETTLE(1)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req0_valid_in(r0_valid), .req0_ready_out(r0_ready),
    .req0_a_in(r0_a), .req0_b_in(r0_b), .req0_op_in(r0_op),
    .req1_valid_in(r1_valid), .req1_ready_out(r1_ready),
    .req1_a_in(r1_a), .req1_b_in(r1_b), .req1_op_in(r1_op),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_id_out(rsp_id),
    .rsp_y_out(rsp_y), .rsp_z_out(rsp_z), .rsp_err_out(rsp_err),
    .alu_a_out(alu_a), .alu_b_out(alu_b), .alu_op_out(alu_op),
    .alu_y_in(alu_y), .alu_z_in(alu_z), .busy_out(busy)
  );

  // ---------------- u_dut4 (SETTLE=4) ----------------
  logic         rst4_n;
  logic         v4, rdy4, v4_1, rdy4_1;
  logic [W-1:0] a4, b4;
  logic [2:0]   op4;
  logic         rsp_valid4, rsp_ready4, rsp_id4, rsp_z4, rsp_err4;
  logic [W-1:0] rsp_y4;
  logic [W-1:0] alu_a4, alu_b4, alu_y4;
  logic [2:0]   alu_op4;
  logic         alu_z4, busy4;

  alu_arbiter #(.WIDTH(W), .SETTLE(4)) u_dut4 (
    .clk_in(clk), .rst_n_in(rst4_n),
    .req0_valid_in(v4), .req0_ready_out(rdy4),
    .req0_a_in(a4), .req0_b_in(b4), .req0_op_in(op4),
    .req1_valid_in(v4_1), .req1_ready_out(rdy4_1),
    .req1_a_in(a4), .req1_b_in(b4), .req1_op_in(op4),
    .rsp_valid_out(rsp_valid4), .rsp_ready_in(rsp_ready4), .rsp_id_out(rsp_id4),
    .rsp_y_out(rsp_y4), .rsp_z_out(rsp_z4), .rsp_err_out(rsp_err4),
    .alu_a_out(alu_a4), .alu_b_out(alu_b4), .alu_op_out(alu_op4),
    .alu_y_in(alu_y4), .alu_z_in(alu_z4), .busy_out(busy4)
  );

  // Behavioural ALU: {z, y}.
  function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] op);
    logic [W-1:0] y;
    case (op)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a * b;
      3'b100:  y = (b == '0) ? '0 : a / b;
      default: y = '0;
    endcase
    return {(y == '0), y};
  endfunction

  always_comb {alu_z, alu_y}   = alu_f(alu_a, alu_b, alu_op);
  always_comb {alu_z4, alu_y4} = alu_f(alu_a4, alu_b4, alu_op4);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_main(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_alu"}, 64'({alu_a, alu_b, alu_op}), 64'd0);
    check({tag, "_rsp"}, 64'({rsp_y, rsp_z, rsp_id, rsp_err}), 64'd0);
    rst_n = 1'b1;
    $display("txn %s: reset", tag);
  endtask

  // Present a request on one requester, wait (bounded) for ready, hold it
  // through the accepting edge, then drop valid.
  task automatic issue(input string tag, input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] op);
    @(negedge clk);
    if (id == 1'b0) begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op;
    end else begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op;
    end
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((id == 1'b0) ? r0_ready : r1_ready) break;
      @(negedge clk);
      #1;
    end
    check({tag, "_ready"}, 64'((id == 1'b0) ? r0_ready : r1_ready), 64'd1);
    @(posedge clk);
    #1;
    if (id == 1'b0) r0_valid = 1'b0;
    else r1_valid = 1'b0;
    $display("txn %s: req%0d op=%b a=%0d b=%0d accepted", tag, id, op, a, b);
  endtask

  // Wait (bounded) for a response, check it, then accept it.
  task automatic wait_rsp(input string tag, input bit id, input logic [W-1:0] y,
                          input bit z, input bit err);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_y"}, 64'(rsp_y), 64'(y));
    check({tag, "_z"}, 64'(rsp_z), 64'(z));
    check({tag, "_err"}, 64'(rsp_err), 64'(err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    $display("txn %s: rsp id=%0d y=%0d z=%0d err=%0d", tag, rsp_id, rsp_y, rsp_z, rsp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; rst4_n = 1'b0;
    r0_valid = 0; r1_valid = 0; rsp_ready = 0;
    r0_a = '0; r0_b = '0; r0_op = '0; r1_a = '0; r1_b = '0; r1_op = '0;
    v4 = 0; v4_1 = 0; a4 = '0; b4 = '0; op4 = '0; rsp_ready4 = 0;
    repeat (2) @(negedge clk);
    check("rst4_busy", 64'(busy4), 64'd0);
    check("rst4_rsp_valid", 64'(rsp_valid4), 64'd0);
    rst4_n = 1'b1;

    // ---- Mid-EXEC reset on the SETTLE=4 instance ----
    @(negedge clk);
    v4 = 1'b1; a4 = 32'd7; b4 = 32'd8; op4 = 3'b000;
    #1;
    check("r4_ready", 64'(rdy4), 64'd1);
    @(posedge clk); #1; v4 = 1'b0;
    @(negedge clk);
    check("r4_busy", 64'(busy4), 64'd1);
    check("r4_alu_b", 64'(alu_b4), 64'd8);
    @(negedge clk);
    check("r4_no_rsp_yet", 64'(rsp_valid4), 64'd0);
    rst4_n = 1'b0;
    #1;
    check("r4_rst_busy", 64'(busy4), 64'd0);
    check("r4_rst_alu", 64'({alu_a4, alu_b4, alu_op4}), 64'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid4 || busy4) n++;
    end
    check("r4_abandoned", 64'(n), 64'd0);
    $display("txn r4: in-flight op abandoned by reset");

    // ---- Latency on SETTLE=4: valid from edge k+4, i.e. 5th negedge ----
    @(negedge clk);
    v4 = 1'b1; a4 = 32'd2; b4 = 32'd3; op4 = 3'b000;
    @(posedge clk); #1; v4 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid4) break;
    end
    check("r4_latency", 64'(n), 64'd5);
    check("r4_y", 64'(rsp_y4), 64'd5);
    rsp_ready4 = 1'b1;
    @(posedge clk); #1; rsp_ready4 = 1'b0;
    $display("txn r4: add 2+3 latency=%0d y=%0d", n, rsp_y4);

    // ---- Main instance: reset state ----
    reset_main("rst0");

    // ---- Single issue, SETTLE=1 ----
    issue("single", 1'b0, 32'd1, 32'd1, 3'b000);
    @(negedge clk);
    check("single_busy", 64'(busy), 64'd1);
    check("single_exec_no_rsp", 64'(rsp_valid), 64'd0);
    check("single_alu_a", 64'(alu_a), 64'd1);
    wait_rsp("single", 1'b0, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("single_idle", 64'(busy), 64'd0);

    // ---- Contention after reset ----
    reset_main("rst1");
    @(negedge clk);
    r0_valid = 1; r0_a = 32'd100; r0_b = 32'd50; r0_op = 3'b001;
    r1_valid = 1; r1_a = 32'd25;  r1_b = 32'd25; r1_op = 3'b010;
    #1;
    check("cont_r0_ready", 64'(r0_ready), 64'd1);
    check("cont_r1_ready", 64'(r1_ready), 64'd0);
    @(posedge clk); #1; r0_valid = 0;
    wait_rsp("cont0", 1'b0, 32'd50, 1'b0, 1'b0);
    check("cont_r1_ready2", 64'(r1_ready), 64'd1);
    @(posedge clk); #1; r1_valid = 0;
    wait_rsp("cont1", 1'b1, 32'd625, 1'b0, 1'b0);
    @(negedge clk);
    r0_valid = 1; r0_a = 32'd3; r0_b = 32'd4; r0_op = 3'b000;
    r1_valid = 1; r1_a = 32'd2; r1_b = 32'd2; r1_op = 3'b010;
    #1;
    check("cont_rr_r0_ready", 64'(r0_ready), 64'd1);
    check("cont_rr_r1_ready", 64'(r1_ready), 64'd0);
    @(posedge clk); #1; r0_valid = 0; r1_valid = 0;
    wait_rsp("cont2", 1'b0, 32'd7, 1'b0, 1'b0);

    // ---- Backpressure ----
    issue("bp", 1'b0, 32'd50, 32'd5, 3'b100);
    @(negedge clk);
    r1_valid = 1; r1_a = 32'd0; r1_b = 32'd0; r1_op = 3'b000;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", 64'({rsp_valid, rsp_z, rsp_y}), {31'd0, 1'b1, 1'b0, 32'd10});
      check("bp_readies", 64'({r0_ready, r1_ready}), 64'd0);
    end
    wait_rsp("bp", 1'b0, 32'd10, 1'b0, 1'b0);
    check("bp_r1_ready", 64'(r1_ready), 64'd1);
    @(posedge clk); #1; r1_valid = 0;
    wait_rsp("zero_add", 1'b1, 32'd0, 1'b1, 1'b0);

    // ---- Zero results ----
    issue("div0", 1'b0, 32'd50, 32'd0, 3'b100);
    wait_rsp("div0", 1'b0, 32'd0, 1'b1, 1'b0);
    issue("sub0", 1'b0, 32'd50, 32'd50, 3'b001);
    wait_rsp("sub0", 1'b0, 32'd0, 1'b1, 1'b0);

    // ---- Unsupported opcode ----
    issue("op7", 1'b0, 32'd9, 32'd9, 3'b111);
    @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
    check("op7_rsp_now", 64'(rsp_valid), 64'd1);
    check("op7_alu_op", 64'(alu_op), 64'd1);
    check("op7_alu_a", 64'(alu_a), 64'd50);
    wait_rsp("op7", 1'b0, 32'd0, 1'b1, 1'b1);
`else
    check("op7_exec", 64'(rsp_valid), 64'd0);
    check("op7_alu_op", 64'(alu_op), 64'd7);
    wait_rsp("op7", 1'b0, 32'd0, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared combinational VeriRISC ALU.
- Accepts operand/opcode requests from two masters over valid/ready handshakes and grants one at a time, round-robin.
- Drives the ALU from registered operands, waits a programmable settle time, then captures y/z.
- Returns the result on one response channel tagged with the requester id.

## Interface
Parameters:
- WIDTH, 32, operand/result width (must match ALU width)
- SETTLE, 1, cycles ALU inputs are held before the result is captured (legal 1..15)

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  reset: one clock; reset is asynchronous and active-low
- req0_valid_in  input  1  requester 0 has a request
- req0_ready_out  output  1  requester 0 request accepted this cycle
- req0_a_in, req0_b_in  input  WIDTH  requester 0 operands
- req0_op_in  input  3  requester 0 opcode
- req1_valid_in, req1_ready_out, req1_a_in, req1_b_in, req1_op_in  as above, for requester 1
- rsp_valid_out  output  1  response available
- rsp_ready_in  input  1  response consumer accepts
- rsp_id_out  output  1  requester served (0/1)
- rsp_y_out  output  WIDTH  captured result
- rsp_z_out  output  1  captured zero flag
- rsp_err_out  output  1  unsupported opcode (see Configuration)
- alu_a_out, alu_b_out  output  WIDTH  ALU operands
- alu_op_out  output  3  ALU opcode
- alu_y_in  input  WIDTH  ALU result
- alu_z_in  input  1  ALU zero flag
- busy_out  output  1  state != IDLE

## Operation
- ALU opcodes:
  - 000 add, 001 sub, 010 mul, 100 div.
  - Divide by zero is an ALU matter: it returns y=0, z=1. It is not an error here.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = the only valid requester; if both are valid, grant = prio.
  - reqN_ready_out = (state==IDLE) && reqN_valid_in && grant==N (combinational).
  - On handshake: latch a/b/op into operand registers driving alu_*_out, latch id, load settle counter with SETTLE-1, go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - On the cycle the counter is 0: capture alu_y_in and alu_z_in into rsp_y_out and rsp_z_out, rsp_err_out=0, go to RESP.
- RESP:
  - rsp_valid_out=1; rsp_* held stable.
  - On rsp_valid_out && rsp_ready_in: go to IDLE, prio = ~rsp_id_out.
- Holding rules:
  - alu_*_out hold their values until the next accept.
  - A requester must hold valid and payload stable until ready.
  - Dropping valid before grant is permitted and ignored.
- Fairness: a continuously valid loser is served next.

## Timing
- Reset values:
  - State IDLE, prio=0, counter=0.
  - All outputs 0: ready, rsp_*, alu_*, busy.
  - Reset asserted mid-operation abandons the in-flight op immediately.
- Latency:
  - Accept at edge k.
  - rsp_valid_out high from edge k+SETTLE.
  - Earliest next accept is on the edge after response acceptance.
  - Throughput: one op per SETTLE+2 cycles with rsp_ready_in held at 1.
- busy_out is high from edge k until response acceptance.
- No combinational path from rsp_ready_in to any output.

## Configuration
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - Opcodes 011, 101, 110, 111 are rejected at accept.
  - alu_*_out keep their previous values; EXEC is skipped (IDLE→RESP in one cycle).
  - Response: y=0, z=1, rsp_err_out=1, id=requester.
- Undefined:
  - All opcodes are issued to the ALU via the normal path.
  - rsp_err_out is tied 0.

## Test plan
- Reset: assert rst_n_in=0 mid-EXEC (SETTLE=4), then release -> all outputs 0 and state IDLE; that op produces no response.
- Single issue: SETTLE=1, req0 add a=1,b=1 -> req0_ready_out=1 same cycle; rsp_valid_out=1 one edge later with y=2, z=0, id=0.
- Contention: after reset, req0 sub 100-50 and req1 mul 25*25 both valid -> req0 served first (y=50), then req1 (y=625, id=1); then both valid again -> req0 served next.
- Backpressure: div 50/5 with rsp_ready_in=0 for 5 cycles -> rsp_valid_out=1 with y=10, z=0 stable; both ready outputs stay 0.
- Zero results: div 50/0 -> y=0, z=1, err=0; sub 50-50 -> y=0, z=1.
- Opcode check: op=3'b111 -> with ALU_ARB_OPCHECK_EN: err=1, y=0, z=1, response one edge after accept, alu_op_out unchanged; without the macro: err=0 and alu_op_out=3'b111.
